switchbox_cfg_loader: RTL
=========================

// Module: switchbox_cfg_loader
// PURPOSE
//  Loads routing configuration words into a switch-box matrix from a word-wide
//  host stream with a valid/ready handshake.
//  Holds a shadow copy, checks every word, and commits all words to the active outputs in one cycle.
//  Active outputs drive the matrix select registers directly.
//  Each 6-bit word is {index[5:3], side[2:0]}.
// PARAMETERS
//  NT  5  pins on the top side and on the bottom side
//  NS  4  pins on the left side and on the right side
//  W   6  config word width (3-bit index, 3-bit side code); fixed, not overridable
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous reset, active low
//  cfg_start   in   1        1-cycle pulse: begin (or restart) a load sequence
//  in_data     in   W        config word
//  in_valid    in   1        in_data valid
//  in_ready    out  1        loader accepts a word this cycle
//  cfg_top     out  NT*W     active words for top pins; pin i at [i*W +: W]
//  cfg_bottom  out  NT*W     active words for bottom pins
//  cfg_left    out  NS*W     active words for left pins
//  cfg_right   out  NS*W     active words for right pins
//  busy        out  1        state != IDLE
//  done        out  1        1-cycle pulse: commit succeeded
//  err         out  1        sticky: last sequence rejected; cleared by next cfg_start
// BEHAVIOUR
//  - Reset: all cfg_* = 0 (side NONE, every pin undriven). in_ready=0, busy=0, done=0, err=0. FSM goes to IDLE.
//  - Reset asserted mid-load discards the shadow copy and the word count.
//  - Word order, N = 2*NT+2*NS = 18 words: top[0..NT-1], bottom[0..NT-1], left[0..NS-1], right[0..NS-1].
//  - FSM:
//    - IDLE -> LOAD on cfg_start. On that edge: word counter=0, err_acc=0, err=0.
//    - LOAD: in_ready=1. A handshake (in_valid & in_ready) writes shadow[cnt] and increments cnt.
//      After the handshake with cnt=N-1: go to CHK if the checksum option is compiled in, else go to COMMIT.
//    - CHK: in_ready=1. One handshake captures the checksum word, then go to COMMIT.
//    - COMMIT: one cycle, in_ready=0. If err_acc=0: copy shadow to cfg_* and pulse done. Otherwise leave cfg_* unchanged and set err=1. Then go to IDLE.
//  - Latency: cfg_* and done update on the 2nd rising edge after the final handshake, i.e. on the edge that ends the COMMIT cycle.
//  - Legality, evaluated per accepted word. Any violation sets err_acc; loading continues to the end of the sequence.
//    - side code > 4 is illegal.
//    - side 1/3 (TOP/BOTTOM) requires index < NT. side 2/4 (RIGHT/LEFT) requires index < NS.
//    - side 0 (NONE) is legal with any index.
//    - self-loop is illegal: a word selecting its own pin, e.g. top[2] = {3'd2, TOP}.
//  - cfg_start while busy: abort and restart at word 0. Shadow contents are don't-care; cfg_* unchanged.
//    If cfg_start coincides with a handshake, cfg_start wins and the word is dropped.
//  - cfg_start during COMMIT: the commit completes, then cfg_start is ignored (no restart).
//  - in_valid while in IDLE is ignored (in_ready=0).
// CONFIGURATION
//  Macro SWITCHBOX_CFG_CHK_EN:
//   - Defined: FSM includes CHK. A checksum word follows word N-1 and must equal the XOR of all N words.
//     A mismatch sets err_acc, so COMMIT rejects the sequence.
//   - Undefined: no CHK state; LOAD goes directly to COMMIT; no checksum word is expected.
// STRUCTURE
//  - Package switchbox_pkg:
//    - side codes: SIDE_NONE=0, SIDE_TOP=1, SIDE_RIGHT=2, SIDE_BOTTOM=3, SIDE_LEFT=4.
//    - CFG_W=6; typedef cfg_word_t {idx[2:0], side[2:0]}.
//    - FSM state enum {IDLE, LOAD, CHK, COMMIT}.
//  - Sub-module switchbox_cfg_check: combinational legality check of one word, given its target side and pin number.
//  - Loader top holds the FSM, counter, shadow/active registers and checksum.
// TESTING
//  1. Reset, then cfg_start plus 18 words of 6'h00 (checksum 6'h00 when CHK_EN) -> done pulses 2 edges after the last handshake; cfg_* all 0; err=0.
//  2. top[0]=6'b001_011 (bottom[1]), right[3]=6'b000_001 (top[0]), all other words 0 -> cfg_top[5:0]=6'h0B, cfg_right[23:18]=6'h01 after done.
//  3. Illegal words, one run each: word 3 = 6'b000_101 (side 5); left[0] = 6'b100_100 (left index 4, NS=4); top[2] = 6'b010_001 (self-loop).
//     -> err=1, no done, cfg_* keep the previous load.
//  4. CHK_EN: legal 18 words followed by a wrong checksum -> err=1, cfg_* unchanged. Next run with the correct XOR -> done, err cleared at cfg_start.
//  5. Abort: cfg_start at word 7, coincident with in_valid -> that word is dropped, the counter restarts. Then a full 18-word load -> only the new data commits.
//  6. rst_n low at word 10 -> cfg_* = 0, busy=0. in_valid held high in IDLE -> in_ready stays 0.

Source files
------------

// File: rtl/switchbox_pkg.sv
// Shared types and constants for the switch-box configuration loader.
// Side codes, the packed config word layout and the loader FSM state type.
package switchbox_pkg;

    localparam int CFG_W = 6;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    typedef struct packed {
        logic [2:0] idx;
        logic [2:0] side;
    } cfg_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHK,
        COMMIT
    } state_e;

endpackage

// File: rtl/switchbox_cfg_loader_if.sv
// Host-side stream into the loader: start pulse plus a valid/ready word channel.
interface switchbox_cfg_loader_if;
    import switchbox_pkg::*;

    logic      cfg_start;
    cfg_word_t in_data;
    logic      in_valid;
    logic      in_ready;

    modport master (output cfg_start, output in_data, output in_valid, input in_ready);
    modport slave  (input cfg_start, input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/switchbox_cfg_check.sv
// Combinational legality check of one config word against the pin it will drive.
// A word is legal when its side code exists, its index names a real pin on that
// side (NONE accepts any index), and it does not select its own pin.
module switchbox_cfg_check
    import switchbox_pkg::*;
#(
    parameter int NT = 5,
    parameter int NS = 4
) (
    input  cfg_word_t  word,
    input  logic [2:0] tgt_side,
    input  logic [2:0] tgt_pin,
    output logic       ok
);

    localparam logic [2:0] NT_L = 3'(NT);
    localparam logic [2:0] NS_L = 3'(NS);

    // Range check by side, then reject a word that loops back onto its own pin
    always_comb begin
        ok = 1'b1;
        case (word.side)
            SIDE_NONE:               ok = 1'b1;
            SIDE_TOP, SIDE_BOTTOM:   ok = (word.idx < NT_L);
            SIDE_RIGHT, SIDE_LEFT:   ok = (word.idx < NS_L);
            default:                 ok = 1'b0;
        endcase
        if ((word.side == tgt_side) && (word.idx == tgt_pin)) begin
            ok = 1'b0;
        end
    end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Switch-box configuration loader.
// Streams N = 2*NT+2*NS words into a shadow copy, checks each word, and copies
// the whole shadow to the active select outputs in one cycle when every word
// was legal. Word order: top[0..NT-1], bottom[..], left[0..NS-1], right[..].
// Optional macro SWITCHBOX_CFG_CHK_EN adds a trailing XOR checksum word.
module switchbox_cfg_loader
    import switchbox_pkg::*;
#(
    parameter int NT = 5,
    parameter int NS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    switchbox_cfg_loader_if.slave  host,
    output logic [NT*CFG_W-1:0]    cfg_top,
    output logic [NT*CFG_W-1:0]    cfg_bottom,
    output logic [NS*CFG_W-1:0]    cfg_left,
    output logic [NS*CFG_W-1:0]    cfg_right,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int W  = CFG_W;
    localparam int N  = 2 * NT + 2 * NS;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [CW-1:0] B_BOT   = CW'(NT);
    localparam logic [CW-1:0] B_LEFT  = CW'(2 * NT);
    localparam logic [CW-1:0] B_RIGHT = CW'(2 * NT + NS);

    state_e         state_reg;
    logic [CW-1:0]  cnt_reg;
    cfg_word_t      shadow_reg [N];
    cfg_word_t      act_reg [N];
    cfg_word_t      xor_reg;
    logic           err_acc_reg;
    logic           err_reg;
    logic           done_reg;
    logic           ready_reg;
    logic           busy_reg;

    logic [2:0]     tgt_side;
    logic [2:0]     tgt_pin;
    logic           word_ok;
    logic           hs;
    logic           restart;

    // Map the word counter onto the side and pin the current word will drive
    always_comb begin
        tgt_side = SIDE_TOP;
        tgt_pin  = 3'(cnt_reg);
        if (cnt_reg >= B_RIGHT) begin
            tgt_side = SIDE_RIGHT;
            tgt_pin  = 3'(cnt_reg - B_RIGHT);
        end else if (cnt_reg >= B_LEFT) begin
            tgt_side = SIDE_LEFT;
            tgt_pin  = 3'(cnt_reg - B_LEFT);
        end else if (cnt_reg >= B_BOT) begin
            tgt_side = SIDE_BOTTOM;
            tgt_pin  = 3'(cnt_reg - B_BOT);
        end
    end

    switchbox_cfg_check #(
        .NT (NT),
        .NS (NS)
    ) u_check (
        .word     (host.in_data),
        .tgt_side (tgt_side),
        .tgt_pin  (tgt_pin),
        .ok       (word_ok)
    );

    assign hs      = host.in_valid & ready_reg;
    // A start pulse during COMMIT is dropped so the commit always completes
    assign restart = host.cfg_start && (state_reg != COMMIT);

    // Loader FSM with counter, shadow/active storage, checksum and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            xor_reg     <= '0;
            err_acc_reg <= 1'b0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_reg[i] <= '0;
                act_reg[i]    <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            if (restart) begin
                // Start wins over a coincident handshake; that word is dropped
                state_reg   <= LOAD;
                cnt_reg     <= '0;
                xor_reg     <= '0;
                err_acc_reg <= 1'b0;
                err_reg     <= 1'b0;
                ready_reg   <= 1'b1;
                busy_reg    <= 1'b1;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        ready_reg <= 1'b0;
                    end
                    LOAD: begin
                        if (hs) begin
                            shadow_reg[cnt_reg] <= host.in_data;
                            xor_reg             <= xor_reg ^ host.in_data;
                            if (!word_ok) begin
                                err_acc_reg <= 1'b1;
                            end
                            if (cnt_reg == LAST) begin
`ifdef SWITCHBOX_CFG_CHK_EN
                                state_reg <= CHK;
`else
                                state_reg <= COMMIT;
                                ready_reg <= 1'b0;
`endif
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                    end
`ifdef SWITCHBOX_CFG_CHK_EN
                    CHK: begin
                        if (hs) begin
                            if (host.in_data != xor_reg) begin
                                err_acc_reg <= 1'b1;
                            end
                            state_reg <= COMMIT;
                            ready_reg <= 1'b0;
                        end
                    end
`endif
                    COMMIT: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b0;
                        if (!err_acc_reg) begin
                            for (int i = 0; i < N; i++) begin
                                act_reg[i] <= shadow_reg[i];
                            end
                            done_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Fan the active words out to the per-side select buses
    for (genvar gi = 0; gi < NT; gi++) begin : g_tb_pins
        assign cfg_top[gi*W +: W]    = act_reg[gi];
        assign cfg_bottom[gi*W +: W] = act_reg[NT + gi];
    end
    for (genvar gi = 0; gi < NS; gi++) begin : g_lr_pins
        assign cfg_left[gi*W +: W]   = act_reg[2*NT + gi];
        assign cfg_right[gi*W +: W]  = act_reg[2*NT + NS + gi];
    end

    assign host.in_ready = ready_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;

endmodule
